// File: rtl/core_defines.sv
// Shared constants for the RV32I pipeline slice used by the writeback stage.
//   XLEN      : data / pc width
//   REG_SEL_W : register selector width
//   NREGS     : number of architectural registers
//   CNT_W     : retired-instruction counter width
//   ZERO_REG  : hard-wired zero register index
//   W_RUN / W_HALT : writeback stage state encodings
package core_defines;

    localparam int XLEN      = 32;
    localparam int REG_SEL_W = 5;
    localparam int NREGS     = 32;
    localparam int CNT_W     = 64;

    localparam logic [REG_SEL_W-1:0] ZERO_REG = '0;

    localparam logic [0:0] W_RUN  = 1'b0;
    localparam logic [0:0] W_HALT = 1'b1;

    // A register write only takes effect for a writeback instruction whose
    // destination is not the zero register.
    function automatic logic reg_write_en(input logic is_wb,
                                          input logic [REG_SEL_W-1:0] sel);
        return is_wb && (sel != ZERO_REG);
    endfunction

endpackage

// File: rtl/w_regfile.sv
// 32x32 architectural register file for the writeback stage.
//   clock, reset      : rising-edge clock, synchronous active-high clear
//   commit            : an instruction commits this cycle
//   is_wb             : the committing instruction writes a register
//   write_sel/result  : destination index and value
//   rs1_sel, rs2_sel  : combinational read indices
//   rs1_data, rs2_data: read data with x0 and same-cycle write bypass
module w_regfile
    import core_defines::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 commit,
    input  logic                 is_wb,
    input  logic [REG_SEL_W-1:0] write_sel,
    input  logic [XLEN-1:0]      result,
    input  logic [REG_SEL_W-1:0] rs1_sel,
    input  logic [REG_SEL_W-1:0] rs2_sel,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data
);

    logic [XLEN-1:0] regs [NREGS];
    logic            write_en;

    assign write_en = commit && reg_write_en(is_wb, write_sel);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[write_sel] <= result;
        end
    end

    // write_en already excludes x0, so a bypass hit never returns a value
    // for index 0; the explicit zero check covers the stored-value path.
    always_comb begin
        rs1_data = regs[rs1_sel];
        if (rs1_sel == ZERO_REG) begin
            rs1_data = '0;
        end else if (write_en && (write_sel == rs1_sel)) begin
            rs1_data = result;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_sel];
        if (rs2_sel == ZERO_REG) begin
            rs2_data = '0;
        end else if (write_en && (write_sel == rs2_sel)) begin
            rs2_data = result;
        end
    end

endmodule

// File: rtl/w_stage.sv
// Writeback stage of the 5-stage RV32I pipeline.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   c_ready               : memory stage presents an instruction to commit
//   cw_pc, cw_write_sel,
//   cw_result, cw_is_wb   : the presented instruction
//   halt_req              : level-sensitive halt request
//   rs1_sel/rs2_sel       : decode read indices
//   rs1_data/rs2_data     : combinational read data with bypass
//   w_ready               : stage accepts an instruction next cycle
//   retired_count         : committed instruction count (wraps)
//   last_pc               : pc of the latest committed instruction
//   halted                : stage is in HALT
module w_stage
    import core_defines::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 c_ready,
    input  logic [XLEN-1:0]      cw_pc,
    input  logic [REG_SEL_W-1:0] cw_write_sel,
    input  logic [XLEN-1:0]      cw_result,
    input  logic                 cw_is_wb,
    input  logic                 halt_req,
    input  logic [REG_SEL_W-1:0] rs1_sel,
    input  logic [REG_SEL_W-1:0] rs2_sel,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 w_ready,
    output logic [CNT_W-1:0]     retired_count,
    output logic [XLEN-1:0]      last_pc,
    output logic                 halted
);

    logic [0:0] state;

    w_regfile u_regfile (
        .clock     (clock),
        .reset     (reset),
        .commit    (c_ready),
        .is_wb     (cw_is_wb),
        .write_sel (cw_write_sel),
        .result    (cw_result),
        .rs1_sel   (rs1_sel),
        .rs2_sel   (rs2_sel),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data)
    );

    // The state simply follows the sampled halt_req level.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= W_RUN;
        end else if (halt_req) begin
            state <= W_HALT;
        end else begin
            state <= W_RUN;
        end
    end

    // Commits are accepted in either state so the one in-flight instruction
    // that was launched before w_ready dropped still drains.
    always_ff @(posedge clock) begin
        if (reset) begin
            retired_count <= '0;
            last_pc       <= '0;
        end else if (c_ready) begin
            retired_count <= retired_count + 1'b1;
            last_pc       <= cw_pc;
        end
    end

    // Gating with reset keeps w_ready low for every reset cycle, including
    // those after the first reset edge has already put the FSM in RUN.
    assign w_ready = (state == W_RUN) && !reset;
    assign halted  = (state == W_HALT);

endmodule

// File: tb/tb_w_stage.sv
// Self-checking testbench for w_stage: driver pushes expected outputs from a
// behavioural model into a queue, a monitor pops and compares each cycle.
module tb_w_stage;
    import core_defines::*;

    logic                 clock;
    logic                 reset;
    logic                 c_ready;
    logic [XLEN-1:0]      cw_pc;
    logic [REG_SEL_W-1:0] cw_write_sel;
    logic [XLEN-1:0]      cw_result;
    logic                 cw_is_wb;
    logic                 halt_req;
    logic [REG_SEL_W-1:0] rs1_sel;
    logic [REG_SEL_W-1:0] rs2_sel;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic                 w_ready;
    logic [CNT_W-1:0]     retired_count;
    logic [XLEN-1:0]      last_pc;
    logic                 halted;

    typedef struct {
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic             ready;
        logic             halted;
        logic [CNT_W-1:0] count;
        logic [XLEN-1:0]  pc;
    } expect_t;

    expect_t exp_q [$];

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state as it stands after the last edge.
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [CNT_W-1:0] m_count;
    logic [XLEN-1:0]  m_pc;
    logic             m_running;

    w_stage dut (
        .clock         (clock),
        .reset         (reset),
        .c_ready       (c_ready),
        .cw_pc         (cw_pc),
        .cw_write_sel  (cw_write_sel),
        .cw_result     (cw_result),
        .cw_is_wb      (cw_is_wb),
        .halt_req      (halt_req),
        .rs1_sel       (rs1_sel),
        .rs2_sel       (rs2_sel),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .w_ready       (w_ready),
        .retired_count (retired_count),
        .last_pc       (last_pc),
        .halted        (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [XLEN-1:0] model_read(input logic [4:0] sel);
        if (sel == 5'd0) return '0;
        if (c_ready && cw_is_wb && cw_write_sel == sel) return cw_result;
        return m_regs[sel];
    endfunction

    task automatic check_output(input string name, input logic [63:0] got,
                                input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Drives one cycle of inputs, records the outputs the model predicts for
    // that cycle, then advances the model across the closing clock edge.
    task automatic apply_stimulus(input logic rst, input logic cr,
                                  input logic [31:0] pc, input logic [4:0] sel,
                                  input logic [31:0] res, input logic wb,
                                  input logic hreq, input logic [4:0] r1,
                                  input logic [4:0] r2);
        expect_t e;
        @(posedge clock);
        #1;
        reset        = rst;
        c_ready      = cr;
        cw_pc        = pc;
        cw_write_sel = sel;
        cw_result    = res;
        cw_is_wb     = wb;
        halt_req     = hreq;
        rs1_sel      = r1;
        rs2_sel      = r2;
        e.rs1    = model_read(r1);
        e.rs2    = model_read(r2);
        e.ready  = m_running && !rst;
        e.halted = !m_running;
        e.count  = m_count;
        e.pc     = m_pc;
        exp_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            m_count   = '0;
            m_pc      = '0;
            m_running = 1'b1;
        end else begin
            if (cr) begin
                m_count = m_count + 64'd1;
                m_pc    = pc;
                if (wb && sel != 5'd0) m_regs[sel] = res;
            end
            m_running = !hreq;
        end
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("rs1_data", 64'(rs1_data), 64'(e.rs1));
                check_output("rs2_data", 64'(rs2_data), 64'(e.rs2));
                check_output("w_ready", 64'(w_ready), 64'(e.ready));
                check_output("halted", 64'(halted), 64'(e.halted));
                check_output("retired_count", retired_count, e.count);
                check_output("last_pc", 64'(last_pc), 64'(e.pc));
            end
        end
    end

    initial begin : driver
        logic       hl;
        logic [4:0] s;
        reset = 1'b1; c_ready = 1'b0; cw_pc = '0; cw_write_sel = '0;
        cw_result = '0; cw_is_wb = 1'b0; halt_req = 1'b0;
        rs1_sel = '0; rs2_sel = '0;
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_count = '0; m_pc = '0; m_running = 1'b1;

        // Reset held three cycles, then every index reads zero.
        repeat (3) apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NREGS; i++)
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));

        // Basic commit and readback.
        apply_stimulus(0, 1, 32'h100, 5, 32'hDEADBEEF, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5, 5);
        // Same-cycle bypass on both ports.
        apply_stimulus(0, 1, 32'h104, 7, 32'h1234, 1, 0, 7, 7);
        // x0 write is dropped but retired.
        apply_stimulus(0, 1, 32'h108, 0, 32'hFFFF, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 7);
        // No-writeback commit.
        apply_stimulus(0, 1, 32'h10C, 3, 32'h55, 0, 0, 3, 3);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 3, 5);
        // Halt with drain.
        apply_stimulus(0, 1, 32'h110, 8, 32'h88, 1, 1, 8, 0);
        apply_stimulus(0, 1, 32'h114, 9, 32'h99, 1, 1, 8, 9);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 9, 8);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 9, 8);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 9, 8);
        // Reset mid-stream drops the presented commit.
        apply_stimulus(1, 1, 32'h118, 9, 32'hA, 1, 0, 9, 9);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 9, 5);

        // Randomized traffic with level-held halt and rare resets.
        hl = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) == 0) hl = ~hl;
            s = 5'($urandom_range(0, 31));
            apply_stimulus($urandom_range(0, 99) == 0,
                           $urandom_range(0, 3) != 0,
                           $urandom, s, $urandom,
                           $urandom_range(0, 4) != 0, hl,
                           ($urandom_range(0, 2) == 0) ? s : 5'($urandom_range(0, 31)),
                           ($urandom_range(0, 2) == 0) ? s : 5'($urandom_range(0, 31)));
        end

        repeat (3) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
